enigma_rotor_stack: RTL and testbench

Parametrised, sequential successor to the fixed two-rotor combinational cipher path. It holds NUM_ROTORS rotor positions with notch-driven odometer stepping. Each accepted 5-bit letter code (A=0 … Z=25) is processed one rotor per cycle, through a fixed reflector, then back, and the cipher code is returned over a valid/ready handshake. It sits between the keyboard decoder (after alphabet_to_binary conversion) and the display/Morse consumers. It replaces the per-rotor instances in the top level.

---
 rtl/enigma_rotor_stack_if.sv | 20 ++
 rtl/enigma_rotor_stack.sv | 145 ++++++++++++++
 tb/tb_enigma_rotor_stack.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_rotor_stack_if.sv
// Letter stream between keyboard decoder, rotor stack and display/Morse consumers.
// The master side drives plaintext in and accepts cipher out; the slave is the rotor stack.
interface enigma_rotor_stack_if;
  logic       in_valid;
  logic [4:0] in_code;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_code;
  logic       out_ready;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_code
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_code
  );
endinterface

// File: rtl/enigma_rotor_stack.sv
// Sequential Enigma-style rotor stack: one rotor per cycle forward, reflector, then back.
// Define DOUBLE_STEP_EN for historical double-stepping of middle rotors; default is pure odometer.
module enigma_rotor_stack #(
  parameter int NUM_ROTORS    = 3,
  parameter int ROTOR_MUL     = 5,
  parameter int ROTOR_MUL_INV = 21,
  parameter int NOTCH         = 25
) (
  input  logic                    clock,
  input  logic                    reset,
  enigma_rotor_stack_if.slave     bus,
  input  logic                    set,
  input  logic [5*NUM_ROTORS-1:0] set_state,
  output logic [5*NUM_ROTORS-1:0] state,
  output logic                    err
);

  typedef enum logic [2:0] {IDLE, STEP, FWD, REFL, BWD, DONE} fsm_t;

  localparam logic [2:0] LAST = 3'(NUM_ROTORS - 1);

  fsm_t       fsm;
  logic [2:0] idx;
  logic [4:0] code_q;
  logic [4:0] pos     [NUM_ROTORS];
  logic [4:0] stepped [NUM_ROTORS];
  logic [4:0] cur_pos, offset, fwd_x, fwd_w, fwd_code, bwd_t, bwd_w, bwd_code, refl_code;

  function automatic logic [4:0] mod26(input logic [11:0] v);
    return 5'(v % 12'd26);
  endfunction

  function automatic logic [4:0] add_mod(input logic [4:0] a, input logic [4:0] b);
    return mod26(12'(a) + 12'(b));
  endfunction

  function automatic logic [4:0] sub_mod(input logic [4:0] a, input logic [4:0] b);
    return mod26(12'(a) + 12'd26 - 12'(b));
  endfunction

  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_state
    assign state[5*g +: 5] = pos[g];
  end

  always_comb begin
    cur_pos = '0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if (idx == 3'(i)) cur_pos = pos[i];
    end
  end

  // Shared datapath for the rotor selected by idx; offset 3i+1 never reaches 26 for i<8.
  always_comb begin
    offset    = mod26(12'd3 * 12'(idx) + 12'd1);
    fwd_x     = add_mod(code_q, cur_pos);
    fwd_w     = mod26(12'(ROTOR_MUL) * 12'(fwd_x) + 12'(offset));
    fwd_code  = sub_mod(fwd_w, cur_pos);
    bwd_t     = sub_mod(fwd_x, offset);
    bwd_w     = mod26(12'(ROTOR_MUL_INV) * 12'(bwd_t));
    bwd_code  = sub_mod(bwd_w, cur_pos);
    refl_code = add_mod(code_q, 5'd13);
  end

  // Carry ripples from the fast rotor using pre-step positions only.
  always_comb begin : step_logic
    logic carry;
    logic inc;
    carry = 1'b1;
    inc   = 1'b0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      inc = carry;
`ifdef DOUBLE_STEP_EN
      if (i >= 1 && i <= NUM_ROTORS - 2 && pos[i] == 5'(NOTCH)) inc = 1'b1;
`endif
      stepped[i] = !inc ? pos[i] : ((pos[i] == 5'd25) ? 5'd0 : pos[i] + 5'd1);
      carry      = inc && (pos[i] == 5'(NOTCH));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm           <= IDLE;
      idx           <= '0;
      code_q        <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_code  <= '0;
      err           <= 1'b0;
      for (int i = 0; i < NUM_ROTORS; i++) pos[i] <= '0;
    end else begin
      err <= 1'b0;
      case (fsm)
        IDLE: begin
          if (set) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
              pos[i] <= (set_state[5*i +: 5] < 5'd26) ? set_state[5*i +: 5] : 5'd0;
            end
          end else if (bus.in_valid) begin
            if (bus.in_code < 5'd26) begin
              code_q       <= bus.in_code;
              bus.in_ready <= 1'b0;
              fsm          <= STEP;
            end else begin
              err <= 1'b1;
            end
          end
        end
        STEP: begin
          for (int i = 0; i < NUM_ROTORS; i++) pos[i] <= stepped[i];
          idx <= '0;
          fsm <= FWD;
        end
        FWD: begin
          code_q <= fwd_code;
          if (idx == LAST) fsm <= REFL;
          else             idx <= idx + 3'd1;
        end
        REFL: begin
          code_q <= refl_code;
          idx    <= LAST;
          fsm    <= BWD;
        end
        BWD: begin
          code_q <= bwd_code;
          if (idx == 3'd0) begin
            bus.out_valid <= 1'b1;
            bus.out_code  <= bwd_code;
            fsm           <= DONE;
          end else begin
            idx <= idx - 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            fsm           <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_rotor_stack.sv
// Scoreboard bench for enigma_rotor_stack: a 2-rotor and a 3-rotor instance checked against
// a letter-level reference model (honours DOUBLE_STEP_EN the same way as the design).
module tb_enigma_rotor_stack;
  localparam int ROTOR_MUL = 5;
  localparam int NOTCH     = 25;

  typedef struct {
    logic [4:0]  in_code;
    logic [4:0]  exp_code;
    logic [14:0] exp_state;
  } sb_t;

  logic        clock, reset, sel, in_valid, out_ready, set;
  logic [4:0]  in_code;
  logic [14:0] set_state;
  logic [9:0]  st2;
  logic [14:0] st3;
  logic        err2, err3;
  logic [14:0] m_state;
  logic        m_in_ready, m_out_valid, m_err;
  logic [4:0]  m_out_code, last_out;
  int          checks = 0;
  int          errors = 0;
  int          mpos [8];
  int          mn;
  sb_t         sbq [$];

  enigma_rotor_stack_if bus2 ();
  enigma_rotor_stack_if bus3 ();

  assign bus2.in_valid  = in_valid & ~sel;
  assign bus3.in_valid  = in_valid & sel;
  assign bus2.in_code   = in_code;
  assign bus3.in_code   = in_code;
  assign bus2.out_ready = out_ready;
  assign bus3.out_ready = out_ready;

  assign m_state     = sel ? st3 : {5'd0, st2};
  assign m_in_ready  = sel ? bus3.in_ready : bus2.in_ready;
  assign m_out_valid = sel ? bus3.out_valid : bus2.out_valid;
  assign m_out_code  = sel ? bus3.out_code : bus2.out_code;
  assign m_err       = sel ? err3 : err2;

  enigma_rotor_stack #(.NUM_ROTORS(2)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2.slave), .set(set & ~sel),
    .set_state(set_state[9:0]), .state(st2), .err(err2)
  );

  enigma_rotor_stack #(.NUM_ROTORS(3)) dut3 (
    .clock(clock), .reset(reset), .bus(bus3.slave), .set(set & sel),
    .set_state(set_state), .state(st3), .err(err3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: letters as plain integers, backward wiring found by searching the forward map.
  function automatic int fwd_wire(input int i, input int x);
    return (ROTOR_MUL * x + 3 * i + 1) % 26;
  endfunction

  function automatic int bwd_wire(input int i, input int y);
    for (int x = 0; x < 26; x++) if (fwd_wire(i, x) == y) return x;
    return 0;
  endfunction

  function automatic int model_cipher(input int code);
    int c = code;
    for (int i = 0; i < mn; i++) c = (fwd_wire(i, (c + mpos[i]) % 26) - mpos[i] + 26) % 26;
    c = (c + 13) % 26;
    for (int i = mn - 1; i >= 0; i--) c = (bwd_wire(i, (c + mpos[i]) % 26) - mpos[i] + 26) % 26;
    return c;
  endfunction

  function automatic logic [14:0] model_state();
    logic [14:0] s = '0;
    for (int i = 0; i < mn; i++) s[5*i +: 5] = 5'(mpos[i]);
    return s;
  endfunction

  task automatic model_step();
    int  old [8];
    bit  carry = 1'b1;
    bit  ds;
    for (int i = 0; i < 8; i++) old[i] = mpos[i];
    for (int i = 0; i < mn; i++) begin
      ds = 1'b0;
`ifdef DOUBLE_STEP_EN
      ds = (i >= 1 && i <= mn - 2 && old[i] == NOTCH);
`endif
      if (carry || ds) mpos[i] = (old[i] + 1) % 26;
      carry = (carry || ds) && old[i] == NOTCH;
    end
  endtask

  task automatic check_output(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic s);
    sel       = s;
    reset     = 1'b1;
    in_valid  = 1'b0;
    set       = 1'b0;
    out_ready = 1'b1;
    mn        = s ? 3 : 2;
    for (int i = 0; i < 8; i++) mpos[i] = 0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic do_set(input logic [14:0] v);
    int f;
    set_state = v;
    set       = 1'b1;
    for (int i = 0; i < mn; i++) begin
      f = int'(v[5*i +: 5]);
      mpos[i] = (f >= 26) ? 0 : f;
    end
    @(posedge clock);
    #1 set = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [4:0] code);
    int  n = 0;
    sb_t item;
    while (!m_in_ready && n < 200) begin
      @(posedge clock);
      #1 n++;
    end
    check_output("in_ready_timeout", {14'd0, m_in_ready}, 15'd1);
    in_valid = 1'b1;
    in_code  = code;
    model_step();
    item.in_code   = code;
    item.exp_code  = 5'(model_cipher(int'(code)));
    item.exp_state = model_state();
    sbq.push_back(item);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!m_in_ready && n < 200) begin
      @(posedge clock);
      #1 n++;
    end
    check_output("idle_timeout", {14'd0, m_in_ready}, 15'd1);
  endtask

  // Monitor: pops one expectation per handshake, independent of the stimulus flow.
  always @(negedge clock) begin
    sb_t item;
    if (!reset && m_out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check_output("unexpected_output", {10'd0, m_out_code}, 15'd31);
      end else begin
        item     = sbq.pop_front();
        last_out = m_out_code;
        check_output("out_code", {10'd0, m_out_code}, {10'd0, item.exp_code});
        check_output("state_at_done", m_state, item.exp_state);
        checks++;
        if (m_out_code == item.in_code) begin
          errors++;
          $display("[TB] FAIL self_map: got %0d, input was %0d", m_out_code, item.in_code);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [14:0] held_state;
    logic [4:0]  held_code;
    int          edges;
    in_code   = '0;
    set_state = '0;
    do_reset(1'b0);

    check_output("reset_state", m_state, 15'd0);
    check_output("reset_out_valid", {14'd0, m_out_valid}, 15'd0);
    check_output("reset_out_code", {10'd0, m_out_code}, 15'd0);
    check_output("reset_err", {14'd0, m_err}, 15'd0);
    check_output("reset_in_ready", {14'd0, m_in_ready}, 15'd1);

    $display("[TB] two rotors: first letter, latency and reciprocity");
    apply_stimulus(5'd0);
    edges = 0;
    while (!m_out_valid && edges < 50) begin
      @(posedge clock);
      #1 edges++;
    end
    check_output("latency", 15'(edges), 15'(2 * mn + 2));
    check_output("first_state", m_state, 15'h0001);
    wait_idle();
    check_output("first_code", {10'd0, last_out}, 15'd13);

    do_reset(1'b0);
    apply_stimulus(5'd13);
    wait_idle();
    check_output("reciprocal_code", {10'd0, last_out}, 15'd0);

    do_reset(1'b0);
    for (int c = 0; c < 26; c++) begin
      apply_stimulus(5'(c));
      wait_idle();
    end

    $display("[TB] two rotors: carry and wrap");
    do_set({5'd0, 5'd0, 5'd25});
    apply_stimulus(5'($urandom_range(0, 25)));
    wait_idle();
    check_output("carry_state", m_state, 15'h0020);
    do_set({5'd0, 5'd25, 5'd25});
    apply_stimulus(5'($urandom_range(0, 25)));
    wait_idle();
    check_output("wrap_state", m_state, 15'd0);

    $display("[TB] three rotors: middle rotor at notch");
    do_reset(1'b1);
    do_set({5'd0, 5'd25, 5'd5});
    apply_stimulus(5'($urandom_range(0, 25)));
    wait_idle();
`ifdef DOUBLE_STEP_EN
    check_output("double_step_state", m_state, {5'd1, 5'd0, 5'd6});
`else
    check_output("odometer_state", m_state, {5'd0, 5'd25, 5'd6});
`endif

    $display("[TB] three rotors: random letters and settings");
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_state = '0;
        for (int i = 0; i < 3; i++) begin
          set_state[5*i +: 5] = ($urandom_range(0, 2) == 0) ? 5'd25 : 5'($urandom_range(0, 31));
        end
        do_set(set_state);
        check_output("set_load", m_state, model_state());
      end
      apply_stimulus(5'($urandom_range(0, 25)));
      wait_idle();
    end

    $display("[TB] backpressure in DONE");
    out_ready = 1'b0;
    apply_stimulus(5'($urandom_range(0, 25)));
    edges = 0;
    while (!m_out_valid && edges < 50) begin
      @(posedge clock);
      #1 edges++;
    end
    check_output("done_reached", {14'd0, m_out_valid}, 15'd1);
    held_code  = m_out_code;
    held_state = m_state;
    for (int k = 0; k < 10; k++) begin
      set_state = 15'($urandom_range(0, 32767));
      in_code   = 5'($urandom_range(0, 31));
      set       = k[0];
      in_valid  = ~k[0];
      @(posedge clock);
      #1;
      check_output("hold_code", {10'd0, m_out_code}, {10'd0, held_code});
      check_output("hold_valid", {14'd0, m_out_valid}, 15'd1);
      check_output("hold_in_ready", {14'd0, m_in_ready}, 15'd0);
      check_output("hold_state", m_state, held_state);
    end
    set       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check_output("release_in_ready", {14'd0, m_in_ready}, 15'd1);
    check_output("release_out_valid", {14'd0, m_out_valid}, 15'd0);

    $display("[TB] invalid code rejection");
    held_state = m_state;
    in_code    = 5'($urandom_range(26, 31));
    in_valid   = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    check_output("err_pulse", {14'd0, m_err}, 15'd1);
    check_output("err_in_ready", {14'd0, m_in_ready}, 15'd1);
    @(posedge clock);
    #1;
    check_output("err_clears", {14'd0, m_err}, 15'd0);
    repeat (2 * mn + 4) @(posedge clock);
    #1;
    check_output("err_no_step", m_state, held_state);
    check_output("err_no_output", {14'd0, m_out_valid}, 15'd0);

    $display("[TB] reset during forward pass");
    do_set({5'd3, 5'd7, 5'd11});
    in_code  = 5'($urandom_range(0, 25));
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check_output("midreset_state", m_state, 15'd0);
    check_output("midreset_out_valid", {14'd0, m_out_valid}, 15'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) mpos[i] = 0;
    repeat (2 * mn + 4) @(posedge clock);
    #1;
    check_output("midreset_idle", {14'd0, m_in_ready}, 15'd1);
    check_output("scoreboard_empty", 15'(sbq.size()), 15'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
